debug_display_mux: RTL
======================

# debug_display_mux

Parametrised debug-probe selector for the seven-segment front panel. Takes NUM_CH probe words of DATA_W bits from the CPU core (instruction, ALU result, register read data, PC, ...) and presents one 16-bit slice on `displayed_number` for the seven-segment driver. Channel and slice are chosen with debounced edge-stepped buttons rather than raw level decoding. The block adds a freeze/snapshot mode and an optional auto-scroll mode. It sits between the core's debug outputs and the seven-segment driver, clocked on the fast board clock.

## Interface
Parameters:
- NUM_CH, 4, number of probe channels (≥2)
- DATA_W, 32, probe width; multiple of 16, ≥16
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a button level change (≥2)
- SCROLL_CYCLES, 100000000, auto-scroll step period in clk cycles (≥2)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  board clock; all state on rising edge
- reset  in  1  synchronous, active-high
- probes  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- btn_next  in  1  raw asynchronous button: step channel
- btn_half  in  1  raw asynchronous button: step 16-bit slice
- freeze  in  1  raw asynchronous switch level: snapshot/hold display
- auto_mode  in  1  auto-scroll enable (honoured only with macro)
- displayed_number  out  16  registered slice to the display driver
- ch_index  out  $clog2(NUM_CH)  current channel
- half_index  out  max(1,$clog2(DATA_W/16))  current slice, 0 = bits [15:0]
- frozen  out  1  snapshot mode active

## Operation
- Each of btn_next, btn_half, freeze: 2-flop synchroniser, then debouncer. Debouncer counter increments while the synchronised level ≠ debounced state and clears when equal. When the counter reaches DEBOUNCE_CYCLES−1 and the level still differs, the debounced state flips and the counter clears.
- Rising edge of debounced btn_next/btn_half gives a 1-cycle pulse; falling edges give nothing.
- next pulse: ch_index +1, wraps NUM_CH−1 → 0; half_index cleared to 0.
- half pulse: half_index +1, wraps DATA_W/16−1 → 0; ch_index unchanged.
- next and half pulses in the same cycle: next wins, half_index = 0.
- Debounced freeze rising: capture the current channel's full DATA_W word into the snapshot register; frozen ← 1. Debounced freeze falling: frozen ← 0.
- While frozen: next pulses are ignored. Half pulses still browse slices of the snapshot. displayed_number is taken from the snapshot, not live probes.
- Not frozen: displayed_number ← probes[ch_index][half_index*16 +: 16], updated every cycle (live).
- Reset values: ch_index 0, half_index 0, frozen 0, displayed_number 0. Snapshot, debounced states, synchronisers and all counters are 0.

## Timing
- Button level change first sampled at edge t: the debounced state flips at edge t+DEBOUNCE_CYCLES+1. The index register updates at edge t+DEBOUNCE_CYCLES+2. displayed_number reflects it at edge t+DEBOUNCE_CYCLES+3.
- Glitch shorter than DEBOUNCE_CYCLES synchronised samples: no state change, counter clears.
- Live data latency: probe change → displayed_number one edge later.
- Reset mid-debounce or mid-freeze: all state returns to reset values on that edge. The first live display (ch 0, slice 0) appears one edge after reset deasserts.

## Configuration
- DBG_AUTOSCROLL_EN defined:
  - While auto_mode=1 and frozen=0, a counter generates an internal step every SCROLL_CYCLES cycles.
  - A step advances half_index; on half wrap it also advances ch_index (wrapping).
  - Any manual next/half pulse clears the scroll counter, and the manual pulse takes effect instead of a coincident auto step.
  - auto_mode=0 or frozen=1 holds the counter at 0.
- DBG_AUTOSCROLL_EN not defined: auto_mode is ignored, no scroll counter is built, and behaviour is manual only.

## Test plan
Use DEBOUNCE_CYCLES=4, SCROLL_CYCLES=8, NUM_CH=4, DATA_W=32.
- Reset, then probes ch0=0x1234ABCD: displayed_number=0xABCD one edge after reset release; ch_index=0, half_index=0.
- btn_half held high 3 synchronised cycles then low: no change. Held high 10 cycles: half_index=1, displayed_number=0x1234, then stable.
- Four next presses: ch_index steps 1,2,3,0. half_index is set to 1 beforehand and reads 0 after the first press.
- Show ch2=0xDEADBEEF, raise freeze, then change ch2 to 0: displayed_number stays 0xBEEF. A half press shows 0xDEAD. A next press leaves ch_index=2. Drop freeze: display shows live 0x0000 (half 1).
- next and half debounced pulses in the same cycle: ch_index+1, half_index=0.
- With DBG_AUTOSCROLL_EN and auto_mode=1: (ch,half) sequence advances every 8 cycles as (0,1),(1,0),(1,1),(2,0). A manual half press mid-period restarts the 8-cycle count.

Source files
------------

// File: rtl/debug_display_mux_if.sv
// Probe/button/display bundle for debug_display_mux.
// master drives probes and panel inputs; slave is the mux.
interface debug_display_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
);
  localparam int CW = $clog2(NUM_CH);
  localparam int HW = (DATA_W / 16 > 1) ? $clog2(DATA_W / 16) : 1;

  logic [NUM_CH*DATA_W-1:0] probes;
  logic                     btn_next;
  logic                     btn_half;
  logic                     freeze;
  logic                     auto_mode;
  logic [15:0]              displayed_number;
  logic [CW-1:0]            ch_index;
  logic [HW-1:0]            half_index;
  logic                     frozen;

  modport master (
    output probes, btn_next, btn_half, freeze, auto_mode,
    input  displayed_number, ch_index, half_index, frozen
  );

  modport slave (
    input  probes, btn_next, btn_half, freeze, auto_mode,
    output displayed_number, ch_index, half_index, frozen
  );
endinterface

// File: rtl/debug_display_mux.sv
// Debug probe selector for the 7-seg panel with debounced stepping and freeze.
// Define DBG_AUTOSCROLL_EN to build the auto-scroll stepper.
module debug_display_mux #(
  parameter int NUM_CH          = 4,
  parameter int DATA_W          = 32,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCROLL_CYCLES   = 100000000
) (
  input logic               clk,
  input logic               reset,
  debug_display_mux_if.slave bus
);
  localparam int CW  = $clog2(NUM_CH);
  localparam int NH  = DATA_W / 16;
  localparam int HW  = (NH > 1) ? $clog2(NH) : 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);

  logic [2:0]     raw;
  logic [2:0]     s1_q, s2_q;
  logic [2:0]     db_q, db_prev_q;
  logic [DBW-1:0] cnt_q [3];
  logic [2:0]     rise, fall;

  logic [CW-1:0]     ch_q, ch_d, ch_nx;
  logic [HW-1:0]     half_q, half_d, half_nx;
  logic              frozen_q, frozen_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [15:0]       disp_q, disp_d;
  logic [DATA_W-1:0] word_live, src;
  logic              next_p, half_p, manual, step;

  // bit 0 next, bit 1 half, bit 2 freeze
  assign raw = {bus.freeze, bus.btn_half, bus.btn_next};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 3; i++) begin
        if (s2_q[i] != db_q[i]) begin
          if (cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            db_q[i]  <= ~db_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign rise   = db_q & ~db_prev_q;
  assign fall   = ~db_q & db_prev_q;
  assign next_p = rise[0] & ~frozen_q;
  assign half_p = rise[1];
  assign manual = next_p | half_p;

`ifdef DBG_AUTOSCROLL_EN
  localparam int SCW = $clog2(SCROLL_CYCLES);
  logic [SCW-1:0] scr_q, scr_d;

  always_comb begin
    scr_d = scr_q + 1'b1;
    step  = 1'b0;
    if (!bus.auto_mode || frozen_q || manual) begin
      scr_d = '0;
    end else if (scr_q == SCW'(SCROLL_CYCLES - 1)) begin
      scr_d = '0;
      step  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) scr_q <= '0;
    else       scr_q <= scr_d;
  end
`else
  logic unused_auto;
  assign unused_auto = bus.auto_mode;
  assign step        = 1'b0;
`endif

  always_comb begin
    word_live = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CW'(k)) word_live = bus.probes[k*DATA_W +: DATA_W];
    end
  end

  assign ch_nx   = (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
  assign half_nx = (half_q == HW'(NH - 1)) ? '0 : half_q + 1'b1;

  always_comb begin
    ch_d   = ch_q;
    half_d = half_q;
    if (next_p) begin
      ch_d   = ch_nx;
      half_d = '0;
    end else if (half_p) begin
      half_d = half_nx;
    end else if (step) begin
      half_d = half_nx;
      if (half_q == HW'(NH - 1)) ch_d = ch_nx;
    end
  end

  always_comb begin
    frozen_d = frozen_q;
    snap_d   = snap_q;
    if (rise[2]) begin
      frozen_d = 1'b1;
      snap_d   = word_live;
    end else if (fall[2]) begin
      frozen_d = 1'b0;
    end
  end

  // Frozen display browses the snapshot, never the live probes
  assign src = frozen_q ? snap_q : word_live;

  always_comb begin
    disp_d = '0;
    for (int j = 0; j < NH; j++) begin
      if (half_q == HW'(j)) disp_d = src[j*16 +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q     <= '0;
      half_q   <= '0;
      frozen_q <= 1'b0;
      snap_q   <= '0;
      disp_q   <= '0;
    end else begin
      ch_q     <= ch_d;
      half_q   <= half_d;
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
      disp_q   <= disp_d;
    end
  end

  assign bus.displayed_number = disp_q;
  assign bus.ch_index         = ch_q;
  assign bus.half_index       = half_q;
  assign bus.frozen           = frozen_q;
endmodule
